// File: rtl/chess_pkg.sv
// chess_pkg: shared FSM states, active-side codes and set-button bit order for the chess clock
package chess_pkg;
  typedef enum logic [2:0] {
    SETUP  = 3'd0,
    READY  = 3'd1,
    RUN_A  = 3'd2,
    RUN_B  = 3'd3,
    PAUSED = 3'd4,
    FLAG   = 3'd5
  } state_t;
  localparam logic [1:0] ACT_NONE = 2'b00;
  localparam logic [1:0] ACT_A    = 2'b01;
  localparam logic [1:0] ACT_B    = 2'b10;
  localparam int ADJ_W       = 4;
  localparam int ADJ_MINUP   = 3;
  localparam int ADJ_MINDOWN = 2;
  localparam int ADJ_SECUP   = 1;
  localparam int ADJ_SECDOWN = 0;
endpackage

// File: rtl/sec_prescaler.sv
// sec_prescaler: counts 0..TICK_DIV-1 while not held; wrap flags the last count of each second
module sec_prescaler #(
  parameter int TICK_DIV = 125000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hold,
  output logic wrap
);
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] cnt;
  assign wrap = ~clear & ~hold & (cnt == PW'(TICK_DIV - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (!hold) cnt <= wrap ? '0 : cnt + 1'b1;
endmodule

// File: rtl/chess_turn_controller.sv
// chess_turn_controller: chess clock game sequencer; gates ticks, set buttons and move increments
module chess_turn_controller
  import chess_pkg::*;
#(
  parameter int TICK_DIV = 125000000,
  parameter int MOVE_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              new_game,
  input  logic              start,
  input  logic              pause,
  input  logic              btn_a,
  input  logic              btn_b,
  input  logic [ADJ_W-1:0]  adj_req,
  input  logic              a_zero,
  input  logic              b_zero,
  output logic              tick_a,
  output logic              tick_b,
  output logic              inc_a,
  output logic              inc_b,
  output logic [ADJ_W-1:0]  adj_out,
  output logic              flag_a,
  output logic              flag_b,
  output logic [1:0]        active,
  output logic [MOVE_W-1:0] moves,
  output logic [2:0]        state
);
  state_t st, nx;
  logic paused_b, sw_a, sw_b, fa, fb, wrap, run_a, run_b, hold, clear;
  assign run_a   = st == RUN_A;
  assign run_b   = st == RUN_B;
  assign state   = st;
  assign active  = run_a ? ACT_A : run_b ? ACT_B : ACT_NONE;
  assign adj_out = st == SETUP ? adj_req : '0;
  // the prescaler only advances on a plain running cycle; flag, pause and new_game freeze it
  assign hold  = ~((run_a & ~a_zero | run_b & ~b_zero) & ~pause & ~new_game);
  assign clear = new_game | sw_a | sw_b | st == SETUP | st == READY;
  sec_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk(clk), .rst_n(rst_n), .clear(clear), .hold(hold), .wrap(wrap)
  );
  always_comb begin
    nx = st;
    sw_a = 1'b0;
    sw_b = 1'b0;
    fa = 1'b0;
    fb = 1'b0;
    if (new_game) nx = SETUP;
    else case (st)
      SETUP:  nx = start ? READY : SETUP;
      READY:  nx = btn_b ? RUN_A : btn_a ? RUN_B : READY;
      RUN_A: begin
        fa   = a_zero;
        sw_a = ~a_zero & ~pause & btn_a;
        nx   = a_zero ? FLAG : pause ? PAUSED : btn_a ? RUN_B : RUN_A;
      end
      RUN_B: begin
        fb   = b_zero;
        sw_b = ~b_zero & ~pause & btn_b;
        nx   = b_zero ? FLAG : pause ? PAUSED : btn_b ? RUN_A : RUN_B;
      end
      PAUSED: nx = pause ? (paused_b ? RUN_B : RUN_A) : PAUSED;
      default: nx = st;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st       <= SETUP;
      paused_b <= 1'b0;
      tick_a   <= 1'b0;
      tick_b   <= 1'b0;
      inc_a    <= 1'b0;
      inc_b    <= 1'b0;
      flag_a   <= 1'b0;
      flag_b   <= 1'b0;
      moves    <= '0;
    end else begin
      st     <= nx;
      tick_a <= wrap & run_a;
      tick_b <= wrap & run_b;
      inc_a  <= sw_a;
      inc_b  <= sw_b;
      if (nx == PAUSED && st != PAUSED) paused_b <= run_b;
      flag_a <= ~new_game & (flag_a | fa);
      flag_b <= ~new_game & (flag_b | fb);
      if (new_game) moves <= '0;
      else if ((sw_a | sw_b) && !(&moves)) moves <= moves + 1'b1;
    end
endmodule

// File: tb/tb_chess_turn_controller.sv
// tb_chess_turn_controller: directed checks of the chess turn controller with TICK_DIV=4, MOVE_W=4
module tb_chess_turn_controller;
  logic clk = 1'b0, rst_n = 1'b0;
  logic new_game = 0, start = 0, pause = 0, btn_a = 0, btn_b = 0, a_zero = 0, b_zero = 0;
  logic [3:0] adj_req = '0, adj_out, moves;
  logic tick_a, tick_b, inc_a, inc_b, flag_a, flag_b;
  logic [1:0] active;
  logic [2:0] state;
  int total = 0, fails = 0;
  chess_turn_controller #(.TICK_DIV(4), .MOVE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .start(start), .pause(pause),
    .btn_a(btn_a), .btn_b(btn_b), .adj_req(adj_req), .a_zero(a_zero), .b_zero(b_zero),
    .tick_a(tick_a), .tick_b(tick_b), .inc_a(inc_a), .inc_b(inc_b), .adj_out(adj_out),
    .flag_a(flag_a), .flag_b(flag_b), .active(active), .moves(moves), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic press_a();
    btn_a = 1; cyc(); btn_a = 0;
  endtask
  task automatic press_b();
    btn_b = 1; cyc(); btn_b = 0;
  endtask
  initial begin
    int first, na, nb, ni;
    #3;
    chk("rst_state", state, 0);
    chk("rst_moves", moves, 0);
    chk("rst_active", active, 0);
    chk("rst_strobes", {tick_a, tick_b, inc_a, inc_b, flag_a, flag_b}, 0);
    chk("rst_adj", adj_out, 0);
    #9 rst_n = 1;
    cyc(); cyc();
    adj_req = 4'b1010; #1;
    chk("adj_setup", adj_out, 4'b1010);
    adj_req = 0;
    start = 1; cyc(); start = 0;
    chk("ready", state, 1);
    press_b();
    chk("run_a", state, 2);
    chk("active_a", active, 1);
    first = 0; na = 0; nb = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (tick_a) begin na++; if (first == 0) first = i; end
      nb += int'(tick_b);
    end
    chk("tick_a_first", first, 4);
    chk("tick_a_count20", na, 5);
    chk("tick_b_idle", nb, 0);
    adj_req = 4'b1010; #1;
    chk("adj_run", adj_out, 0);
    adj_req = 0;
    cyc(); cyc();
    press_a();
    chk("sw_inc_a", inc_a, 1);
    chk("sw_tick_a", tick_a, 0);
    chk("sw_moves", moves, 1);
    chk("sw_state", state, 3);
    first = 0; ni = 0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      ni += int'(inc_a);
      if (tick_b && first == 0) first = i;
    end
    chk("inc_a_one_cycle", ni, 0);
    chk("tick_b_first", first, 4);
    press_b();
    chk("sw_inc_b", inc_b, 1);
    chk("moves2", moves, 2);
    cyc();
    pause = 1; cyc(); pause = 0;
    chk("paused", state, 4);
    chk("paused_active", active, 0);
    na = 0;
    for (int i = 0; i < 10; i++) begin cyc(); na += int'(tick_a | tick_b); end
    chk("paused_ticks", na, 0);
    pause = 1; cyc(); pause = 0;
    chk("resume_state", state, 2);
    first = 0;
    for (int i = 1; i <= 6; i++) begin cyc(); if (tick_a && first == 0) first = i; end
    chk("resume_tick_first", first, 3);
    pause = 1; btn_a = 1; cyc(); pause = 0; btn_a = 0;
    chk("pause_wins_state", state, 4);
    chk("pause_wins_inc", inc_a, 0);
    pause = 1; cyc(); pause = 0;
    press_b();
    chk("btn_b_ignored", state, 2);
    chk("btn_b_ignored_inc", inc_b, 0);
    chk("btn_b_ignored_moves", moves, 2);
    press_a();
    chk("moves3", moves, 3);
    b_zero = 1; btn_b = 1; cyc(); btn_b = 0;
    chk("flag_state", state, 5);
    chk("flag_b", flag_b, 1);
    chk("flag_no_inc", inc_b, 0);
    chk("flag_moves", moves, 3);
    chk("flag_active", active, 0);
    ni = 0;
    press_a(); ni += int'(inc_a | inc_b | tick_a | tick_b);
    press_b(); ni += int'(inc_a | inc_b | tick_a | tick_b);
    pause = 1; cyc(); pause = 0; ni += int'(inc_a | inc_b | tick_a | tick_b);
    cyc(); ni += int'(inc_a | inc_b | tick_a | tick_b);
    chk("flag_terminal_strobes", ni, 0);
    chk("flag_terminal_state", state, 5);
    chk("flag_terminal_moves", moves, 3);
    b_zero = 0;
    new_game = 1; cyc(); new_game = 0;
    chk("ng_state", state, 0);
    chk("ng_moves", moves, 0);
    chk("ng_flag", flag_b, 0);
    start = 1; cyc(); start = 0;
    press_a();
    chk("ready_a_to_run_b", state, 3);
    press_b(); press_a();
    cyc();
    new_game = 1; cyc(); new_game = 0;
    chk("ng_run_b_state", state, 0);
    chk("ng_run_b_moves", moves, 0);
    start = 1; cyc(); start = 0;
    press_b();
    for (int i = 0; i < 17; i++) if (i % 2 == 0) press_a(); else press_b();
    chk("moves_saturate", moves, 15);
    chk("sat_state", state, 3);
    a_zero = 1;
    press_b();
    chk("entry_zero_run_a", state, 2);
    cyc();
    chk("entry_zero_flag", state, 5);
    chk("entry_zero_flag_a", flag_a, 1);
    chk("entry_zero_no_tick", tick_a, 0);
    a_zero = 0;
    new_game = 1; cyc(); new_game = 0;
    start = 1; cyc(); start = 0;
    btn_a = 1; btn_b = 1; cyc(); btn_a = 0; btn_b = 0;
    chk("both_ready", state, 2);
    chk("both_ready_moves", moves, 0);
    press_a(); press_b();
    chk("pre_async_moves", moves, 2);
    cyc();
    #2 rst_n = 0;
    #1;
    chk("async_state", state, 0);
    chk("async_moves", moves, 0);
    chk("async_active", active, 0);
    chk("async_strobes", {tick_a, tick_b, inc_a, inc_b}, 0);
    #3 rst_n = 1;
    cyc(); cyc();
    chk("post_rst_state", state, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
